// File: rtl/mult_display_pkg.sv
// Shared types and sizing for the multiplier display path.
// The product width, digit count and converter state encoding live here.
package mult_display_pkg;

  localparam int PRODUCT_W  = 16;
  localparam int BCD_DIGITS = 5;
  localparam int CNT_W      = $clog2(PRODUCT_W + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: add 3 to any BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential signed-product to BCD converter using shift-and-add-3.
// One shift per clock in CONVERT; the result registers update only on CONVERT->DONE.
module product_bcd_converter
  import mult_display_pkg::*;
#(
  parameter int WIDTH  = PRODUCT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Product,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Neg,
  output logic [4*DIGITS-1:0]   Bcd
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CW    = (WIDTH == PRODUCT_W) ? CNT_W : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

  conv_state_t            state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [ACC_W-1:0]       acc, acc_n, acc_adj, bcd_n;
  logic [WIDTH-1:0]       mag, mag_n;
  logic                   neg_cap, neg_cap_n, neg_n;
  logic [ACC_W+WIDTH-1:0] shifted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_add3 u_add3 (
      .digit    (acc[4*i +: 4]),
      .adjusted (acc_adj[4*i +: 4])
    );
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    acc_n     = acc;
    mag_n     = mag;
    neg_cap_n = neg_cap;
    bcd_n     = Bcd;
    neg_n     = Neg;
    shifted   = {acc_adj, mag} << 1;

    case (state)
      IDLE: begin
        if (Start) begin
          neg_cap_n = Product[WIDTH-1];
          // 16'h8000 negates to itself, which read unsigned is the correct 32768
          mag_n     = Product[WIDTH-1] ? (~Product + 1'b1) : Product;
          acc_n     = '0;
          cnt_n     = '0;
          state_n   = CONVERT;
        end
      end
      CONVERT: begin
        acc_n = shifted[ACC_W+WIDTH-1:WIDTH];
        mag_n = shifted[WIDTH-1:0];
        cnt_n = cnt + 1'b1;
        if (cnt == LAST_SHIFT) begin
          state_n = DONE;
          bcd_n   = shifted[ACC_W+WIDTH-1:WIDTH];
          neg_n   = neg_cap;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mag     <= '0;
      neg_cap <= 1'b0;
      Bcd     <= '0;
      Neg     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      acc     <= acc_n;
      mag     <= mag_n;
      neg_cap <= neg_cap_n;
      Bcd     <= bcd_n;
      Neg     <= neg_n;
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule
